two_d_filter_ctrl: RTL and testbench

Sequencing and configuration controller for the 3x3 `two_d_filter` datapath. It tracks the raster position of every valid input pixel and flags the last pixel of each line and of each frame. It marks which pixels complete a fully interior 3x3 window and aborts a stalled frame after a timeout. It holds the nine filter coefficients in a shadow/active double buffer so coefficient updates never land mid-frame.

---
 rtl/two_d_filter_pkg.sv | 27 ++
 rtl/two_d_filter_ctrl_if.sv | 26 ++
 rtl/two_d_filter_coef_bank.sv | 49 ++++
 rtl/two_d_filter_ctrl.sv | 127 ++++++++++++
 tb/tb_two_d_filter_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/two_d_filter_pkg.sv
// Shared types and constants for the 3x3 filter controller.
// Tap k maps to coefficient (r,c) as k=(r-1)*3+(c-1).
package two_d_filter_pkg;

    localparam int NUM_TAPS   = 9;
    localparam int DEF_COEF_W = 9;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [3:0] TAP_1_1 = 4'd0;
    localparam logic [3:0] TAP_1_2 = 4'd1;
    localparam logic [3:0] TAP_1_3 = 4'd2;
    localparam logic [3:0] TAP_2_1 = 4'd3;
    localparam logic [3:0] TAP_2_2 = 4'd4;
    localparam logic [3:0] TAP_2_3 = 4'd5;
    localparam logic [3:0] TAP_3_1 = 4'd6;
    localparam logic [3:0] TAP_3_2 = 4'd7;
    localparam logic [3:0] TAP_3_3 = 4'd8;

    function automatic logic [3:0] tap_idx(input int r, input int c);
        return 4'((r - 1) * 3 + (c - 1));
    endfunction

endpackage

// File: rtl/two_d_filter_ctrl_if.sv
// Coefficient configuration bus: shadow writes and commit requests.
// The host side is master, the controller side is slave.
interface two_d_filter_ctrl_if #(
    parameter int COEF_W = 9
) ();

    logic              cfg_wr;
    logic [3:0]        cfg_addr;
    logic [COEF_W-1:0] cfg_data;
    logic              cfg_commit;

    modport master (
        output cfg_wr,
        output cfg_addr,
        output cfg_data,
        output cfg_commit
    );

    modport slave (
        input cfg_wr,
        input cfg_addr,
        input cfg_data,
        input cfg_commit
    );

endinterface

// File: rtl/two_d_filter_coef_bank.sv
// Shadow/active coefficient double buffer.
// A commit copies the shadow bank including a write in the same cycle.
module two_d_filter_coef_bank
    import two_d_filter_pkg::*;
#(
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic                       clk,
    input  logic                       aclr,
    two_d_filter_ctrl_if.slave         cfg,
    input  logic                       commit,
    output logic [NUM_TAPS*COEF_W-1:0] coef_flat
);

    logic [COEF_W-1:0] shadow     [NUM_TAPS];
    logic [COEF_W-1:0] active     [NUM_TAPS];
    logic [COEF_W-1:0] shadow_nxt [NUM_TAPS];

    // Addresses above the last tap never match, so they are dropped.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            shadow_nxt[k] = shadow[k];
            if (cfg.cfg_wr && cfg.cfg_addr == 4'(k))
                shadow_nxt[k] = cfg.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= shadow_nxt[k];
                if (commit)
                    active[k] <= shadow_nxt[k];
            end
        end
    end

    always_comb begin
        coef_flat = '0;
        for (int k = 0; k < NUM_TAPS; k++)
            coef_flat[k*COEF_W +: COEF_W] = active[k];
    end

endmodule

// File: rtl/two_d_filter_ctrl.sv
// Raster sequencer, frame timeout and coefficient commit control
// for the 3x3 two_d_filter datapath.
module two_d_filter_ctrl
    import two_d_filter_pkg::*;
#(
    parameter int COLS    = 12,
    parameter int ROWS    = 16,
    parameter int COEF_W  = 9,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       aclr,
    input  logic                       data_valid_in,
    two_d_filter_ctrl_if.slave         cfg,
    output logic [NUM_TAPS*COEF_W-1:0] coef_flat,
    output logic [$clog2(COLS)-1:0]    x_pos,
    output logic [$clog2(ROWS)-1:0]    y_pos,
    output logic                       pix_valid,
    output logic                       win_valid,
    output logic                       sof,
    output logic                       eol,
    output logic                       eof,
    output logic                       abort,
    output logic                       busy,
    output logic                       commit_pending
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          apply_q;

    logic last_x;
    logic last_y;
    logic frame_end;
    logic tmo_hit;
    logic commit_now;

    always_comb begin
        last_x     = (x_cnt == XW'(COLS - 1));
        last_y     = (y_cnt == YW'(ROWS - 1));
        frame_end  = (state == ACTIVE) && data_valid_in && last_x && last_y;
        tmo_hit    = (state == ACTIVE) && !data_valid_in &&
                     (tmo_cnt == TW'(TIMEOUT - 1));
        commit_now = ((state == IDLE) && cfg.cfg_commit) || apply_q;
    end

    assign busy = (state == ACTIVE);

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state          <= IDLE;
            x_cnt          <= '0;
            y_cnt          <= '0;
            tmo_cnt        <= '0;
            apply_q        <= 1'b0;
            commit_pending <= 1'b0;
            x_pos          <= '0;
            y_pos          <= '0;
            pix_valid      <= 1'b0;
            win_valid      <= 1'b0;
            sof            <= 1'b0;
            eol            <= 1'b0;
            eof            <= 1'b0;
            abort          <= 1'b0;
        end else begin
            pix_valid <= data_valid_in;
            win_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            abort     <= 1'b0;

            // Frame end turns any commit into an apply one cycle later.
            apply_q <= (frame_end || tmo_hit) &&
                       (commit_pending || cfg.cfg_commit);
            if (commit_now)
                commit_pending <= 1'b0;
            else if ((state == ACTIVE) && cfg.cfg_commit &&
                     !frame_end && !tmo_hit)
                commit_pending <= 1'b1;

            if (data_valid_in) begin
                x_pos     <= x_cnt;
                y_pos     <= y_cnt;
                sof       <= (state == IDLE);
                win_valid <= (x_cnt >= XW'(2)) && (y_cnt >= YW'(2));
                eol       <= last_x;
                eof       <= last_x && last_y;
                tmo_cnt   <= '0;
                if (last_x) begin
                    x_cnt <= '0;
                    y_cnt <= last_y ? '0 : y_cnt + YW'(1);
                end else begin
                    x_cnt <= x_cnt + XW'(1);
                end
                state <= (last_x && last_y) ? IDLE : ACTIVE;
            end else if (state == ACTIVE) begin
                if (tmo_hit) begin
                    abort   <= 1'b1;
                    state   <= IDLE;
                    x_cnt   <= '0;
                    y_cnt   <= '0;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

    two_d_filter_coef_bank #(
        .COEF_W (COEF_W)
    ) u_coef_bank (
        .clk       (clk),
        .aclr      (aclr),
        .cfg       (cfg),
        .commit    (commit_now),
        .coef_flat (coef_flat)
    );

endmodule

// File: tb/tb_two_d_filter_ctrl.sv
// Directed bench for two_d_filter_ctrl: raster flags, timeout abort,
// coefficient commit deferral and asynchronous reset.
module tb_two_d_filter_ctrl;

    logic       clk = 1'b0;
    logic       aclr = 1'b0;
    logic       data_valid_in = 1'b0;
    logic [80:0] coef_flat;
    logic [3:0] x_pos;
    logic [3:0] y_pos;
    logic pix_valid, win_valid, sof, eol, eof, abort, busy, commit_pending;

    int total = 0;
    int bad   = 0;
    int sof_n, eol_n, eof_n, win_n, pix_n;

    two_d_filter_ctrl_if #(.COEF_W(9)) cfg ();

    two_d_filter_ctrl dut (
        .clk            (clk),
        .aclr           (aclr),
        .data_valid_in  (data_valid_in),
        .cfg            (cfg),
        .coef_flat      (coef_flat),
        .x_pos          (x_pos),
        .y_pos          (y_pos),
        .pix_valid      (pix_valid),
        .win_valid      (win_valid),
        .sof            (sof),
        .eol            (eol),
        .eof            (eof),
        .abort          (abort),
        .busy           (busy),
        .commit_pending (commit_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] tap(input int k);
        return coef_flat[k*9 +: 9];
    endfunction

    task automatic cfg_idle();
        cfg.cfg_wr     = 1'b0;
        cfg.cfg_addr   = 4'd0;
        cfg.cfg_data   = 9'd0;
        cfg.cfg_commit = 1'b0;
    endtask

    initial begin
        cfg_idle();
        tick();
        tick();
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_coef", coef_flat, 0);
        chk("rst_pending", commit_pending, 0);
        chk("rst_abort", abort, 0);
        chk("rst_xy", {x_pos, y_pos}, 0);
        aclr = 1'b1;
        tick();

        // IDLE commit of tap 4
        cfg.cfg_wr = 1'b1; cfg.cfg_addr = 4'd4; cfg.cfg_data = 9'h1FF;
        tick();
        cfg_idle();
        chk("shadow_only", coef_flat, 0);
        cfg.cfg_commit = 1'b1;
        tick();
        cfg_idle();
        chk("idle_commit_tap4", tap(4), 9'h1FF);
        chk("idle_commit_all", coef_flat, 81'h1FF << 36);

        // write + commit same cycle
        cfg.cfg_wr = 1'b1; cfg.cfg_addr = 4'd8; cfg.cfg_data = 9'd3;
        cfg.cfg_commit = 1'b1;
        tick();
        cfg_idle();
        chk("bypass_tap8", coef_flat, (81'h1FF << 36) | (81'd3 << 72));

        // out-of-range address is ignored
        cfg.cfg_wr = 1'b1; cfg.cfg_addr = 4'd12; cfg.cfg_data = 9'h155;
        tick();
        cfg_idle();
        cfg.cfg_commit = 1'b1;
        tick();
        cfg_idle();
        chk("addr12_noop", coef_flat, (81'h1FF << 36) | (81'd3 << 72));

        // full frame, valid every other cycle, deferred commit of tap 0
        sof_n = 0; eol_n = 0; eof_n = 0; win_n = 0; pix_n = 0;
        for (int p = 0; p < 192; p++) begin
            data_valid_in = 1'b1;
            tick();
            if (sof) sof_n++;
            if (eol) eol_n++;
            if (eof) eof_n++;
            if (win_valid) win_n++;
            if (pix_valid) pix_n++;
            if (p == 0) chk("f1_first_xy_sof", {x_pos, y_pos, sof}, 9'b0000_0000_1);
            if (p == 100) chk("f1_mid_tap0", tap(0), 0);
            if (p == 191) begin
                chk("f1_eof", eof, 1);
                chk("f1_eof_eol", eol, 1);
                chk("f1_eof_xy", {x_pos, y_pos}, {4'd11, 4'd15});
                chk("f1_busy_after_eof", busy, 0);
                chk("f1_pending_at_eof", commit_pending, 1);
                chk("f1_tap0_at_eof", tap(0), 0);
            end
            data_valid_in = 1'b0;
            if (p == 5) begin
                cfg.cfg_wr = 1'b1; cfg.cfg_addr = 4'd0; cfg.cfg_data = 9'd7;
                cfg.cfg_commit = 1'b1;
            end
            tick();
            if (p == 5) begin
                cfg_idle();
                chk("f1_pending_set", commit_pending, 1);
                chk("f1_tap0_held", tap(0), 0);
            end
        end
        chk("f1_tap0_applied", tap(0), 9'd7);
        chk("f1_pending_clear", commit_pending, 0);
        chk("f1_sof_count", sof_n, 1);
        chk("f1_eol_count", eol_n, 16);
        chk("f1_eof_count", eof_n, 1);
        chk("f1_win_count", win_n, 140);
        chk("f1_pix_count", pix_n, 192);

        // back-to-back frames, valid every cycle
        data_valid_in = 1'b1;
        for (int p = 0; p < 192; p++) begin
            tick();
            if (p == 191) begin
                chk("f2_eof", eof, 1);
                chk("f2_eof_xy", {x_pos, y_pos}, {4'd11, 4'd15});
            end
        end
        tick();
        chk("f3_sof", sof, 1);
        chk("f3_xy", {x_pos, y_pos}, 0);
        chk("f3_busy", busy, 1);

        // 20 pixels then idle until timeout, commit of tap 1 deferred
        for (int p = 1; p < 20; p++) tick();
        chk("tmo_last_xy", {x_pos, y_pos}, {4'd7, 4'd1});
        data_valid_in = 1'b0;
        cfg.cfg_wr = 1'b1; cfg.cfg_addr = 4'd1; cfg.cfg_data = 9'd5;
        cfg.cfg_commit = 1'b1;
        tick();
        cfg_idle();
        chk("tmo_pending", commit_pending, 1);
        for (int i = 2; i <= 63; i++) tick();
        chk("tmo_no_abort_63", abort, 0);
        chk("tmo_busy_63", busy, 1);
        tick();
        chk("tmo_abort", abort, 1);
        chk("tmo_busy_0", busy, 0);
        chk("tmo_tap1_held", tap(1), 0);
        tick();
        chk("tmo_abort_pulse", abort, 0);
        chk("tmo_tap1_applied", tap(1), 9'd5);
        chk("tmo_pending_clear", commit_pending, 0);
        data_valid_in = 1'b1;
        tick();
        chk("tmo_restart_sof", sof, 1);
        chk("tmo_restart_xy", {x_pos, y_pos}, 0);

        // reset mid-frame with a pending commit
        for (int p = 1; p < 50; p++) tick();
        data_valid_in = 1'b0;
        cfg.cfg_wr = 1'b1; cfg.cfg_addr = 4'd2; cfg.cfg_data = 9'd6;
        cfg.cfg_commit = 1'b1;
        tick();
        cfg_idle();
        chk("rm_pending", commit_pending, 1);
        aclr = 1'b0;
        #1;
        chk("rm_coef", coef_flat, 0);
        chk("rm_pending_clr", commit_pending, 0);
        chk("rm_flags", {pix_valid, win_valid, sof, eol, eof, abort, busy}, 0);
        chk("rm_xy", {x_pos, y_pos}, 0);
        tick();
        aclr = 1'b1;
        tick();
        data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
        chk("rm_sof", sof, 1);
        chk("rm_xy_after", {x_pos, y_pos}, 0);
        chk("rm_pix_valid", pix_valid, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
